fret_event_queue: RTL and testbench
===================================

// Module: fret_event_queue
// PURPOSE
//  Consumes the 8-bit level-style key vector from the controller reader and turns it into discrete key events.
//  Three stages: 2-flop synchronise, per-key debounce, press/release edge detect.
//  Events are queued in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake.
//  The game note-judge logic pops events at its own pace.
// PARAMETERS
//  DEBOUNCE_CYCLES  4096  consecutive clk cycles a synced key must differ from its stable value before the stable value flips (>=2)
//  FIFO_DEPTH       8     event FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1   system clock, all logic on posedge
//  reset           in   1   asynchronous, active-high reset
//  keys            in   8   raw key levels from controller reader (1 = pressed)
//  ev_ready        in   1   consumer accepts head event this cycle
//  clear_overflow  in   1   synchronous clear of overflow flag
//  ev_valid        out  1   FIFO not empty; head event on ev_key/ev_press
//  ev_key          out  3   index 0..7 of key that changed
//  ev_press        out  1   1 = press (0->1), 0 = release (1->0)
//  stable_keys     out  8   debounced key levels
//  ev_count        out  4   FIFO occupancy 0..FIFO_DEPTH
//  overflow        out  1   sticky: an event was lost
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync regs, stable_keys, pending, all debounce counters -> 0
//   - FIFO empty, ev_valid=0, ev_key=0, ev_press=0, ev_count=0, overflow=0
//  Sync: keys -> s1 -> s2; s2 is the only source for debounce.
//  Debounce (per bit i, counter ceil(log2(DEBOUNCE_CYCLES)) bits):
//   - s2[i]==stable[i]: counter <= 0
//   - s2[i]!=stable[i] and counter==DEBOUNCE_CYCLES-1: stable[i] <= s2[i]; counter <= 0 ("flip")
//   - otherwise: counter +1
//   - a glitch shorter than DEBOUNCE_CYCLES cycles never changes stable_keys
//  Pending (8-bit pend mask + 8-bit pend_type):
//   - on flip of bit i: pend[i]<=1, pend_type[i]<=new stable value
//   - if pend[i] already set at the flip, the two changes cancel: pend[i]<=0, overflow<=1
//  Arbiter:
//   - each cycle, if pend!=0 and FIFO not full (evaluated at start of cycle), push lowest-index pending bit, clear its pend bit
//   - one push per cycle max; a bit flipping in the push cycle sets pend again, no cancel
//  FIFO: FWFT, circular rd/wr pointers wrap modulo FIFO_DEPTH.
//   - pop when ev_valid & ev_ready
//   - push and pop in same cycle: ev_count unchanged
//   - full: no push (pend holds, nothing lost); empty: pop ignored
//   - data pushed into empty FIFO appears on outputs the next cycle
//   - ev_key/ev_press hold head value while ev_valid=0 and ev_ready=0
//  Latency: keys change sampled at edge T -> stable_keys at edge T+1+DEBOUNCE_CYCLES -> ev_valid high after edge T+DEBOUNCE_CYCLES+3 (FIFO empty).
//  Overflow: set by cancellation only; cleared by clear_overflow unless a set occurs the same cycle (set wins).
//  Reset mid-operation drops all pending and queued events immediately; no events are generated for keys already held at reset release until debounced (stable starts at 0, so held keys produce press events).
// TESTING (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8)
//  1. keys=8'h01 held -> stable_keys=8'h01 at T+5, ev_valid at T+7 with ev_key=0, ev_press=1; ev_ready=1 -> ev_valid=0 next cycle, ev_count=0.
//  2. keys[3] 1-cycle and 3-cycle pulses -> no stable change, no events, ev_count=0.
//  3. keys 8'h00->8'hA5 at once -> four events in order keys 0,2,5,7 all press, on 4 consecutive pushes, ev_count=4.
//  4. ev_ready=0, toggle keys[1] slowly 12 times -> ev_count saturates at 8, then overflow=1 after next cancel; ev_ready=1 drains 8 correct alternating events; clear_overflow -> overflow=0.
//  5. FIFO holding 3 entries, push and pop same cycle -> ev_count stays 3, order preserved across pointer wrap.
//  6. reset asserted mid-debounce with 2 queued events -> all outputs 0 asynchronously, no stale event after release.

Source files
------------

// File: rtl/fret_event_queue.sv
// rtl/fret_event_queue.sv - key vector synchroniser, debouncer and press/release event FIFO
//
// Pipeline: keys -> 2-flop sync -> per-key debounce -> pending mask -> stage register -> FWFT FIFO.
// The stage register sits between the arbiter and the FIFO so that an event
// pushed into an empty FIFO becomes visible one cycle after the arbiter picks it.
// The arbiter only stages an entry when the FIFO has room for it including
// any entry already staged, so a staged entry is always written on the next edge.

module fret_event_queue #(
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   keys,
  input  logic                         ev_ready,
  input  logic                         clear_overflow,
  output logic                         ev_valid,
  output logic [2:0]                   ev_key,
  output logic                         ev_press,
  output logic [7:0]                   stable_keys,
  output logic [$clog2(FIFO_DEPTH):0]  ev_count,
  output logic                         overflow
);

  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  // Synchroniser
  logic [7:0] s1_q;
  logic [7:0] s2_q;

  // Debounce state
  logic [7:0]     stable_q;
  logic [7:0]     stable_d;
  logic [7:0]     flip;
  logic [DBW-1:0] cnt_q [8];
  logic [DBW-1:0] cnt_d [8];

  // Pending events and cancellation
  logic [7:0] pend_q;
  logic [7:0] pend_d;
  logic [7:0] ptype_q;
  logic [7:0] ptype_d;
  logic       ovf_set;
  logic       overflow_q;
  logic       overflow_d;

  // Arbiter / stage register
  logic [2:0]    sel_idx;
  logic          sel_found;
  logic [CW-1:0] occupancy;
  logic          room;
  logic          stage_take;
  logic          stage_vld_q;
  logic [2:0]    stage_key_q;
  logic          stage_press_q;

  // FIFO storage
  logic [2:0]    mem_key_q   [FIFO_DEPTH];
  logic          mem_press_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;

  // Two-flop synchroniser for the raw key levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= keys;
      s2_q <= s1_q;
    end
  end

  // Per-key debounce: count consecutive cycles of disagreement, flip on the last one
  always_comb begin
    flip     = '0;
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
        flip[i]     = 1'b1;
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DBW'(1);
      end
    end
  end

  // Debounce registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Lowest-index pending key wins the arbiter
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx   = 3'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Room check counts the entry already in the stage register as occupied
  always_comb begin
    occupancy  = count_q + CW'(stage_vld_q);
    room       = (occupancy < CW'(FIFO_DEPTH));
    stage_take = sel_found & room;
  end

  // Pending mask update: arbiter clears its pick, flips set or cancel
  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    ovf_set = 1'b0;
    if (stage_take) begin
      pend_d[sel_idx] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (flip[i]) begin
        // A second change before the first left the mask cancels both,
        // unless the first is leaving this very cycle.
        if (pend_q[i] && !(stage_take && (sel_idx == 3'(i)))) begin
          pend_d[i] = 1'b0;
          ovf_set   = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = stable_d[i];
        end
      end
    end
  end

  // Sticky overflow: a cancellation beats a simultaneous clear
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Pending, overflow and stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q        <= '0;
      ptype_q       <= '0;
      overflow_q    <= 1'b0;
      stage_vld_q   <= 1'b0;
      stage_key_q   <= '0;
      stage_press_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      ptype_q       <= ptype_d;
      overflow_q    <= overflow_d;
      stage_vld_q   <= stage_take;
      stage_key_q   <= sel_idx;
      stage_press_q <= ptype_q[sel_idx];
    end
  end

  // FIFO handshake and occupancy
  always_comb begin
    push    = stage_vld_q;
    pop     = (count_q != '0) & ev_ready;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage and circular pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_key_q[i]   <= '0;
        mem_press_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_key_q[wr_ptr_q]   <= stage_key_q;
        mem_press_q[wr_ptr_q] <= stage_press_q;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Head of FIFO drives the outputs directly (first-word fall-through)
  always_comb begin
    ev_valid    = (count_q != '0);
    ev_key      = mem_key_q[rd_ptr_q];
    ev_press    = mem_press_q[rd_ptr_q];
    stable_keys = stable_q;
    ev_count    = count_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_fret_event_queue.sv
// tb/tb_fret_event_queue.sv - randomized and directed bench for fret_event_queue against a queue-based model

module tb_fret_event_queue;

  localparam int DC = 4;
  localparam int D  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keys = '0;
  logic       ev_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_key;
  logic       ev_press;
  logic [7:0] stable_keys;
  logic [3:0] ev_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  fret_event_queue #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .keys(keys), .ev_ready(ev_ready),
    .clear_overflow(clear_overflow), .ev_valid(ev_valid), .ev_key(ev_key),
    .ev_press(ev_press), .stable_keys(stable_keys), .ev_count(ev_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model state: key sample history, debounced levels, pending set, event queue
  logic [7:0] hist[$];
  logic [7:0] m_stable;
  logic [7:0] m_pend;
  logic [7:0] m_ptype;
  logic       m_ovf;
  logic       m_stage_vld;
  logic [3:0] m_stage;
  logic [3:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DC + 2; i++) hist.push_back(8'h00);
    m_stable = '0; m_pend = '0; m_ptype = '0; m_ovf = 1'b0;
    m_stage_vld = 1'b0; m_stage = '0;
    m_q.delete();
  endtask

  // One clock edge of the reference: a key flips once its synchronised level
  // (two samples late) has disagreed with the stable level for DC edges in a row.
  task automatic model_edge();
    int n;
    int sel;
    logic [7:0] flipm;
    logic [7:0] pend_pre;
    logic [7:0] h;
    logic take;
    logic room;
    logic cancel;
    n = hist.size();
    flipm = '0;
    for (int i = 0; i < 8; i++) begin
      flipm[i] = 1'b1;
      for (int k = 0; k < DC; k++) begin
        h = hist[n-2-k];
        if (h[i] == m_stable[i]) flipm[i] = 1'b0;
      end
    end
    room = (m_q.size() + (m_stage_vld ? 1 : 0)) < D;
    sel = 0;
    for (int i = 7; i >= 0; i--) if (m_pend[i]) sel = i;
    take = (m_pend != 0) && room;
    if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
    if (m_stage_vld) m_q.push_back(m_stage);
    m_stage_vld = take;
    if (take) m_stage = {3'(sel), m_ptype[sel]};
    pend_pre = m_pend;
    if (take) m_pend[sel] = 1'b0;
    cancel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (flipm[i]) begin
        if (pend_pre[i] && !(take && sel == i)) begin
          m_pend[i] = 1'b0;
          cancel = 1'b1;
        end else begin
          m_pend[i] = 1'b1;
          m_ptype[i] = ~m_stable[i];
        end
      end
    end
    m_stable = m_stable ^ flipm;
    if (cancel) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    hist.push_back(keys);
    void'(hist.pop_front());
  endtask

  task automatic compare();
    logic [3:0] head;
    check("stable", stable_keys, m_stable);
    check("count", ev_count, m_q.size());
    check("valid", ev_valid, m_q.size() != 0);
    check("ovf", overflow, m_ovf);
    if (m_q.size() > 0) begin
      head = m_q[0];
      check("key", ev_key, head[3:1]);
      check("press", ev_press, head[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    compare();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, ev_valid, 0);
    check({tag, "_key"}, ev_key, 0);
    check({tag, "_press"}, ev_press, 0);
    check({tag, "_stable"}, stable_keys, 0);
    check({tag, "_count"}, ev_count, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int b;
    int rprob;
    int w;
    int exp_keys[4];
    exp_keys = '{0, 2, 5, 7};
    model_reset();

    // Reset state
    step(); step();
    check_all_zero("rst0");
    reset = 1'b0;
    step();

    // Single press: latency to stable_keys and ev_valid
    keys = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t1_stable", stable_keys, (k >= 6) ? 8'h01 : 8'h00);
      check("t1_valid", ev_valid, k >= 8);
    end
    check("t1_key", ev_key, 0);
    check("t1_press", ev_press, 1);
    ev_ready = 1'b1;
    step();
    check("t1_popvalid", ev_valid, 0);
    check("t1_popcount", ev_count, 0);

    // Short glitches on key 3 never reach stable_keys
    keys = 8'h09; step(); keys = 8'h01;
    repeat (8) step();
    keys = 8'h09; repeat (3) step(); keys = 8'h01;
    repeat (10) step();
    check("t2_stable", stable_keys, 8'h01);
    check("t2_count", ev_count, 0);

    // Simultaneous presses come out lowest key first
    keys = 8'h00; repeat (14) step();
    ev_ready = 1'b0;
    keys = 8'hA5; repeat (12) step();
    check("t3_count", ev_count, 4);
    ev_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("t3_key", ev_key, exp_keys[j]);
      check("t3_press", ev_press, 1);
      step();
    end
    keys = 8'h00; repeat (14) step();

    // Fill the FIFO, then cancellations raise overflow
    ev_ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      keys[1] = ~keys[1];
      repeat (8) step();
    end
    check("t4_count", ev_count, 8);
    check("t4_ovf", overflow, 1);
    ev_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("t4_key", ev_key, 1);
      check("t4_press", ev_press, (j % 2) == 0);
      step();
    end
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    check("t4_clr", overflow, 0);

    // Push and pop in the same cycle with three entries held
    ev_ready = 1'b0;
    keys = 8'h07; repeat (10) step();
    check("t5_count", ev_count, 3);
    keys = keys | 8'h08; step();
    keys = keys | 8'h10; step();
    keys = keys | 8'h20; step();
    w = 0;
    while (!m_stage_vld && w < 20) begin step(); w++; end
    check("t5_wait", w < 20, 1);
    ev_ready = 1'b1;
    repeat (3) begin
      step();
      check("t5_hold", ev_count, 3);
    end
    repeat (12) step();

    // Reset in the middle of debounce with two events queued
    ev_ready = 1'b0;
    keys = 8'h3C; repeat (10) step();
    check("t6_count", ev_count, 2);
    keys = 8'hC0; step(); step();
    reset = 1'b1;
    #1;
    check_all_zero("t6_rst");
    model_reset();
    step(); step();
    reset = 1'b0;
    ev_ready = 1'b1;
    w = 0;
    while (!ev_valid && w < 20) begin step(); w++; end
    check("t6_wait", ev_valid, 1);
    check("t6_key", ev_key, 6);
    check("t6_press", ev_press, 1);
    repeat (10) step();

    // Randomized traffic with varying consumer pace
    for (int p = 0; p < 6; p++) begin
      rprob = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          keys = 8'($urandom());
        end else if ($urandom_range(0, 7) == 0) begin
          b = $urandom_range(0, 7);
          keys[b] = ~keys[b];
        end
        ev_ready = ($urandom_range(0, 99) < rprob);
        clear_overflow = ($urandom_range(0, 49) == 0);
        step();
      end
    end
    clear_overflow = 1'b0;
    ev_ready = 1'b1;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
